mips_cpu_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer owning the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Sits beside the ALU on the execute stage and takes rs/rt operands from the register file. Runs an iterative shift-add multiply or restoring divide, then signals completion; the control unit stalls MFHI/MFLO and new mul/div issues while `busy` is high.

---
 rtl/mips_cpu_muldiv_ctrl_if.sv | 16 +
 rtl/mips_cpu_muldiv_ctrl.sv | 105 ++++++++++
 tb/tb_mips_cpu_muldiv_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_ctrl_if.sv
// mips_cpu_muldiv_ctrl_if: issue, MTHI/MTLO and HI/LO result bundle of the mul/div sequencer.
interface mips_cpu_muldiv_ctrl_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output start, op, a, b, mthi, mtlo, wdata, input busy, done, hi, lo);
   modport slave (input start, op, a, b, mthi, mtlo, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_ctrl.sv
// mips_cpu_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module mips_cpu_muldiv_ctrl (
   input logic clk,
   input logic reset_n,
   mips_cpu_muldiv_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t      state;
   logic [5:0]  cnt;
   logic [1:0]  op_r;
   logic [31:0] a_mag, b_mag;
   logic        res_neg, dvd_neg;
   logic [63:0] acc;
   logic [31:0] rem;
   logic        busy_q, done_q;
   logic [31:0] hi_q, lo_q;
   logic        signed_op, a_neg, b_neg;
   logic [31:0] a_in, b_in;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [63:0] prod;
   logic [31:0] quo, rmd, a_orig, fix_hi, fix_lo;
   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.a[31];
   assign b_neg     = signed_op & bus.b[31];
   assign a_in      = a_neg ? -bus.a : bus.a;
   assign b_in      = b_neg ? -bus.b : bus.b;
   assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
   // Divide: acc[31:0] shifts dividend bits out while quotient bits shift in.
   assign div_sh    = {rem, acc[31]};
   assign div_ge    = div_sh >= {1'b0, b_mag};
   assign div_diff  = div_sh[31:0] - b_mag;
   assign prod      = res_neg ? -acc : acc;
   assign quo       = res_neg ? -acc[31:0] : acc[31:0];
   assign rmd       = dvd_neg ? -rem : rem;
   assign a_orig    = dvd_neg ? -a_mag : a_mag;
   assign fix_hi    = !op_r[1] ? prod[63:32] : (b_mag == 32'd0) ? a_orig : rmd;
   assign fix_lo    = !op_r[1] ? prod[31:0] : (b_mag == 32'd0) ? 32'hFFFFFFFF : quo;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op_r    <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         res_neg <= 1'b0;
         dvd_neg <= 1'b0;
         acc     <= '0;
         rem     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               op_r    <= bus.op;
               a_mag   <= a_in;
               b_mag   <= b_in;
               res_neg <= a_neg ^ b_neg;
               dvd_neg <= a_neg;
               cnt     <= '0;
               rem     <= '0;
               acc     <= bus.op[1] ? {32'b0, a_in} : {32'b0, b_in};
               busy_q  <= 1'b1;
               state   <= RUN;
`ifdef MULDIV_FAST_MUL_EN
               if (!bus.op[1]) begin
                  acc   <= {32'b0, a_in} * {32'b0, b_in};
                  state <= FIX;
               end
`else
`endif
            end else begin
               if (bus.mthi) hi_q <= bus.wdata;
               if (bus.mtlo) lo_q <= bus.wdata;
            end
            RUN: begin
               cnt <= cnt + 6'd1;
               if (op_r[1]) begin
                  rem       <= div_ge ? div_diff : div_sh[31:0];
                  acc[31:0] <= {acc[30:0], div_ge};
               end else
                  acc <= {mul_sum, acc[31:1]};
               if (cnt == 6'd31) state <= FIX;
            end
            FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// tb_mips_cpu_muldiv_ctrl: table vectors plus corner sequences, results checked from a scoreboard queue.
module tb_mips_cpu_muldiv_ctrl;
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   mips_cpu_muldiv_ctrl_if bus ();
   mips_cpu_muldiv_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_bad = 0;
   logic [63:0] exp_q[$];
   string name_q[$];
   logic [31:0] m_hi = '0, m_lo = '0;
   logic prev_done = 1'b0;
   vec_t v[14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      logic signed [31:0] dx, dy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      dx = x;
      dy = y;
      if (o == 2'd0) return sx * sy;
      if (o == 2'd1) return {32'b0, x} * {32'b0, y};
      if (y == 32'd0) return {x, 32'hFFFFFFFF};
      if (o == 2'd3) return {x % y, x / y};
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      return {dx % dy, dx / dy};
   endfunction
   always @(posedge clk) begin
      logic [63:0] e;
      string nm;
      #1;
      if (bus.done) begin
         chk("done_single_pulse", {31'b0, prev_done}, 32'd0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 want no result pending");
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, " hi"}, bus.hi, e[63:32]);
            chk({nm, " lo"}, bus.lo, e[31:0]);
         end
      end
      prev_done = bus.done;
   end
   task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
   endtask
   task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el, input string nm);
      int lat, nb, exp_lat;
      exp_lat = 33;
`ifdef MULDIV_FAST_MUL_EN
      if (!o[1]) exp_lat = 1;
`endif
      drive_start(o, x, y);
      exp_q.push_back({eh, el});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      nb  = 0;
      while (!bus.done && lat < 80) begin
         nb += int'(bus.busy);
         if (lat == exp_lat / 2) begin
            chk({nm, " hold_hi"}, bus.hi, m_hi);
            chk({nm, " hold_lo"}, bus.lo, m_lo);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " busy_cycles"}, nb, exp_lat);
      chk({nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
      m_hi = eh;
      m_lo = el;
   endtask
   task automatic wait_done(input string nm);
      int n = 0;
      while (!bus.done && n < 80) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, " done_seen"}, 32'(bus.done), 32'd1);
   endtask
   task automatic move_to(input logic h, input logic l, input logic [31:0] d);
      @(negedge clk);
      bus.mthi  = h;
      bus.mtlo  = l;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
   endtask
   initial begin
      logic [1:0]  ro;
      logic [31:0] rx, ry;
      logic [63:0] re;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.a     = '0;
      bus.b     = '0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      bus.wdata = '0;
      v[0]  = '{2'd0, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6};
      v[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      v[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      v[3]  = '{2'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
      v[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      v[5]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      v[6]  = '{2'd3, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF};
      v[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
      v[8]  = '{2'd1, 32'h12345678, 32'd0,        32'd0,        32'd0};
      v[9]  = '{2'd2, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF};
      v[10] = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
      v[11] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
      v[12] = '{2'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
      v[13] = '{2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
      #12;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset lo", bus.lo, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 14; i++)
         run(v[i].op, v[i].a, v[i].b, v[i].hi, v[i].lo, $sformatf("vec%0d", i));
      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         ry = (i == 3) ? 32'd0 : $urandom;
         re = model(ro, rx, ry);
         run(ro, rx, ry, re[63:32], re[31:0], $sformatf("rnd%0d_op%0d", i, ro));
      end
      move_to(1'b1, 1'b0, 32'h1234);
      chk("mthi hi", bus.hi, 32'h1234);
      chk("mthi lo_kept", bus.lo, m_lo);
      m_hi = 32'h1234;
      move_to(1'b0, 1'b1, 32'h5678);
      chk("mtlo lo", bus.lo, 32'h5678);
      chk("mtlo hi_kept", bus.hi, 32'h1234);
      m_lo = 32'h5678;
      move_to(1'b1, 1'b1, 32'hA5A55A5A);
      chk("mthilo hi", bus.hi, 32'hA5A55A5A);
      chk("mthilo lo", bus.lo, 32'hA5A55A5A);
      m_hi = 32'hA5A55A5A;
      m_lo = 32'hA5A55A5A;
      drive_start(2'd2, 32'h80000000, 32'hFFFFFFFF);
      exp_q.push_back({32'd0, 32'h80000000});
      name_q.push_back("div_ovf_midrun");
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'd1;
      bus.a     = 32'd3;
      bus.b     = 32'd5;
      bus.mthi  = 1'b1;
      bus.wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      chk("busy_mthi hi", bus.hi, m_hi);
      chk("busy_mthi busy", 32'(bus.busy), 32'd1);
      wait_done("div_ovf_midrun");
      m_hi = 32'd0;
      m_lo = 32'h80000000;
      repeat (3) @(posedge clk);
      #1;
      chk("midrun_start busy", 32'(bus.busy), 32'd0);
      drive_start(2'd1, 32'd2, 32'd3);
      bus.mthi  = 1'b1;
      bus.wdata = 32'h00000BAD;
      exp_q.push_back({32'd0, 32'd6});
      name_q.push_back("start_vs_mthi");
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      chk("start_vs_mthi hi", bus.hi, m_hi);
      wait_done("start_vs_mthi");
      m_hi = 32'd0;
      m_lo = 32'd6;
      move_to(1'b1, 1'b0, 32'h1111);
      m_hi = 32'h1111;
      drive_start(2'd2, 32'hFFFFFFF9, 32'd2);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort hi", bus.hi, 32'd0);
      chk("abort lo", bus.lo, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      run(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_after_reset");
      repeat (40) @(posedge clk);
      #1;
      chk("scoreboard empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
